// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS control path.
// Contents:
//   - opcode and R-type funct codes
//   - ALU operation codes (alu_op_t)
//   - controller state codes (mc_state_t)
//   - ALU decode class (alu_class_t)
//   - ALU B-source and next-PC select encodings
//   - op_supported(): legality check for the non-R-type opcodes
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BREX    = 4'd8,
    S_IEX     = 4'd9,
    S_IWB     = 4'd10,
    S_JEX     = 4'd11
  } mc_state_t;

  // Which decoder drives the ALU in a given state
  typedef enum logic [1:0] {
    CLS_ADD   = 2'b00,
    CLS_SUB   = 2'b01,
    CLS_RTYPE = 2'b10,
    CLS_IMM   = 2'b11
  } alu_class_t;

  // ALU B-source select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for every supported opcode other than R-type (R-type legality
  // depends on funct and is resolved by mc_aludec).
  function automatic logic op_supported(input logic [5:0] opc);
    case (opc)
      OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J: op_supported = 1'b1;
      default:                                op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: ALU operation and immediate-extension decode.
// Ports:
//   cls         in  ALU decode class chosen by the controller state
//   op          in  instr[31:26]
//   funct       in  instr[5:0]
//   alucontrol  out ALU operation
//   immext      out 1 = zero-extend immediate, 0 = sign-extend
//   funct_legal out funct is one of the supported R-type operations
module mc_aludec
  import mips_pkg::*;
(
  input  alu_class_t  cls,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output alu_op_t     alucontrol,
  output logic        immext,
  output logic        funct_legal
);

  alu_op_t fn_op_s;
  alu_op_t imm_op_s;
  logic    imm_zext_s;

  // R-type funct to ALU operation, with legality flag
  always_comb begin
    fn_op_s     = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  fn_op_s = ALU_ADD;
      FN_SUB:  fn_op_s = ALU_SUB;
      FN_AND:  fn_op_s = ALU_AND;
      FN_OR:   fn_op_s = ALU_OR;
      FN_SLT:  fn_op_s = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  // Immediate-ALU opcode to ALU operation; logical immediates zero-extend
  always_comb begin
    imm_op_s   = ALU_ADD;
    imm_zext_s = 1'b0;
    case (op)
      OP_ADDI: imm_op_s = ALU_ADD;
      OP_ANDI: begin
        imm_op_s   = ALU_AND;
        imm_zext_s = 1'b1;
      end
      OP_ORI: begin
        imm_op_s   = ALU_OR;
        imm_zext_s = 1'b1;
      end
      OP_SLTI: imm_op_s = ALU_SLT;
      default: imm_op_s = ALU_ADD;
    endcase
  end

  // Select the decoder that owns the ALU this cycle
  always_comb begin
    alucontrol = ALU_ADD;
    immext     = 1'b0;
    case (cls)
      CLS_ADD:   alucontrol = ALU_ADD;
      CLS_SUB:   alucontrol = ALU_SUB;
      CLS_RTYPE: alucontrol = fn_op_s;
      CLS_IMM: begin
        alucontrol = imm_op_s;
        immext     = imm_zext_s;
      end
      default:   alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing the multicycle MIPS datapath.
// Each instruction takes 3-5 cycles; FETCH, MEMRD and MEMWR stall on
// mem_ready. All outputs are combinational from the registered state
// (plus mem_ready / zero for the strobes).
// Ports:
//   clk, reset            clock, async active-high reset
//   op, funct, zero       instruction fields from IR, ALU zero flag
//   mem_ready             memory access completes this cycle
//   iord .. pcen          datapath selects and write enables
//   retire                pulse in the last cycle of an instruction
//   illegal               pulse in DECODE for an unsupported op/funct
module mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       immext,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       retire,
  output logic       illegal
);

  mc_state_t  state_r;
  mc_state_t  state_next_s;
  alu_class_t alu_cls_s;
  alu_op_t    alu_op_s;
  logic       funct_legal_s;
  logic       decode_ok_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       pcen_s;
  logic       retire_s;
  logic       illegal_s;

  mc_aludec u_aludec (
    .cls         (alu_cls_s),
    .op          (op),
    .funct       (funct),
    .alucontrol  (alu_op_s),
    .immext      (immext),
    .funct_legal (funct_legal_s)
  );

  assign alucontrol  = alu_op_s;
  assign decode_ok_s = (op == OP_RTYPE) ? funct_legal_s : op_supported(op);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; unknown encodings recover to FETCH
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) state_next_s = S_DECODE;
        else           state_next_s = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:  state_next_s = S_MEMADR;
          OP_RTYPE: begin
            if (funct_legal_s) state_next_s = S_RTYPEEX;
            else               state_next_s = S_FETCH;
          end
          OP_BEQ, OP_BNE: state_next_s = S_BREX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next_s = S_IEX;
          OP_J:           state_next_s = S_JEX;
          default:        state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_SW) state_next_s = S_MEMWR;
        else             state_next_s = S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ready) state_next_s = S_MEMWB;
        else           state_next_s = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready) state_next_s = S_FETCH;
        else           state_next_s = S_MEMWR;
      end
      S_RTYPEEX: state_next_s = S_RTYPEWB;
      S_IEX:     state_next_s = S_IWB;
      S_MEMWB, S_RTYPEWB, S_BREX, S_IWB, S_JEX: state_next_s = S_FETCH;
      default:   state_next_s = S_FETCH;
    endcase
  end

  // Per-state output decode (strobes are gated by reset below)
  always_comb begin
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PCSRC_ALU;
    alu_cls_s  = CLS_ADD;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    pcen_s     = 1'b0;
    retire_s   = 1'b0;
    illegal_s  = 1'b0;
    case (state_r)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        irwrite_s = mem_ready;
        pcen_s    = mem_ready;
      end
      S_DECODE: begin
        alusrcb   = SRCB_IMMSH;
        illegal_s = ~decode_ok_s;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
        retire_s   = mem_ready;
      end
      S_RTYPEEX: begin
        alusrca   = 1'b1;
        alu_cls_s = CLS_RTYPE;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      S_BREX: begin
        alusrca   = 1'b1;
        alu_cls_s = CLS_SUB;
        pcsrc     = PCSRC_ALUOUT;
        pcen_s    = (op == OP_BNE) ? ~zero : zero;
        retire_s  = 1'b1;
      end
      S_IEX: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_IMM;
        alu_cls_s = CLS_IMM;
      end
      S_IWB: begin
        // IR still holds the instruction, so the IEX decode is repeated
        alu_cls_s  = CLS_IMM;
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      S_JEX: begin
        pcsrc    = PCSRC_JUMP;
        pcen_s   = 1'b1;
        retire_s = 1'b1;
      end
      default: begin
        iord = 1'b0;
      end
    endcase
  end

  // No strobe may reach the datapath while reset is held
  assign memwrite = memwrite_s & ~reset;
  assign irwrite  = irwrite_s  & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign pcen     = pcen_s     & ~reset;
  assign retire   = retire_s   & ~reset;
  assign illegal  = illegal_s  & ~reset;

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the MIPS core. It replaces the single-cycle decoder when the datapath is rebuilt around one shared instruction/data memory and the IR/A/B/ALUOut holding registers. A Moore FSM sequences each instruction over 3–5 cycles, waiting on a memory-ready handshake for every memory access. It drives all datapath mux selects and write enables.

## Interface

Parameters: none.

Clock and reset: one clock; reset is asynchronous and active-high, ports `clk` and `reset`.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- op  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  IR load enable
- regdst  out  1  write register select: 1 = rd, 0 = rt
- memtoreg  out  1  write-back select: 1 = Data register, 0 = ALUOut
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = A
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2
- immext  out  1  immediate extension: 1 = zero-extend (andi/ori), 0 = sign-extend
- alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC load enable
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  one-cycle pulse when an unsupported op/funct is decoded

## Operation

States:
- FETCH
  - Outputs: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
  - irwrite = pcen = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE
  - Outputs: alusrca=0, alusrcb=11, alucontrol=010 (branch target computed into ALUOut).
  - Next state:
    - lw/sw → MEMADR
    - R-type with a legal funct → RTYPEEX
    - beq/bne → BREX
    - addi/andi/ori/slti → IEX
    - j → JEX
    - anything else → FETCH, with illegal=1
- MEMADR
  - Outputs: alusrca=1, alusrcb=10, immext=0, add.
  - lw → MEMRD; sw → MEMWR.
- MEMRD
  - Outputs: iord=1.
  - Holds until mem_ready=1, then → MEMWB.
- MEMWB
  - Outputs: regdst=0, memtoreg=1, regwrite=1, retire=1.
  - → FETCH.
- MEMWR
  - Outputs: iord=1, memwrite=1 held until mem_ready=1.
  - On mem_ready=1: retire=1, → FETCH.
- RTYPEEX
  - Outputs: alusrca=1, alusrcb=00, alucontrol from funct (add 100000, sub 100010, and 100100, or 100101, slt 101010).
  - → RTYPEWB.
- RTYPEWB
  - Outputs: regdst=1, memtoreg=0, regwrite=1, retire=1.
  - → FETCH.
- BREX
  - Outputs: alusrca=1, alusrcb=00, sub, pcsrc=01, retire=1.
  - pcen = zero for beq; pcen = ~zero for bne.
  - → FETCH.
- IEX
  - Outputs: alusrca=1, alusrcb=10.
  - addi: add, immext=0. andi: and, immext=1. ori: or, immext=1. slti: slt, immext=0.
  - → IWB.
- IWB
  - Outputs: regdst=0, memtoreg=0, regwrite=1, retire=1.
  - Holds immext and alucontrol from IEX.
  - → FETCH.
- JEX
  - Outputs: pcsrc=10, pcen=1, retire=1.
  - → FETCH.

Output defaults: every output not listed for a state is 0, except alucontrol (default 010) and pcsrc (default 00).

## Timing

- Reset:
  - State is forced to FETCH asynchronously.
  - While reset=1: memwrite, irwrite, regwrite, pcen, retire and illegal are all 0, regardless of mem_ready.
  - The first fetch is possible on the first rising edge after reset deasserts.
  - Reset mid-instruction abandons the instruction: no write strobe is issued and retire does not fire.
- Latency with mem_ready always 1: lw 5 cycles, sw 4, R-type 4, addi/andi/ori/slti 4, beq/bne 3, j 3. Each wait cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Strobes are combinational from the registered state plus mem_ready/zero. No output is registered.
- illegal and retire are never asserted in the same cycle.

## Structure

- Shared package `mips_pkg` holds:
  - opcode and funct localparams;
  - the `alu_op_t` enum (3-bit codes above);
  - the `mc_state_t` enum;
  - the alusrcb and pcsrc select encodings.
- One sub-module, `mc_aludec`, maps (state-class, op, funct) to alucontrol, immext and funct legality. The FSM and output decode live in `mc_controller`.

## Test plan

- **Reset mid-lw:** hold mem_ready=1; assert reset while in MEMRD → state is FETCH immediately, regwrite stays 0. After release, the next cycle is FETCH with pcen=1.
- **lw with memory wait:** op=100011, mem_ready=0 for 2 cycles in MEMRD → 7 cycles total. regwrite=1 and memtoreg=1 only in the final cycle, together with retire.
- **R-type sub then slt:** op=000000, funct=100010 → alucontrol=110 in RTYPEEX, regdst=1 in RTYPEWB. Then funct=101010 → alucontrol=111.
- **Branches:** beq with zero=1 → pcen=1, pcsrc=01 in BREX. bne with zero=1 → pcen=0. Both take 3 cycles.
- **Immediates:** ori (001101) → immext=1, alucontrol=001 in both IEX and IWB. addi (001000) → immext=0, alucontrol=010.
- **Illegal decode:** op=111111, or R-type with funct=000111 → illegal=1 in DECODE, next state FETCH, no write strobe, retire=0.
